// File: rtl/darkriscv_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, requests words from instruction memory and
// buffers them with their PC in a prefetch FIFO. Optional STALL_CNT via `define FETCH_STATS_EN.
module darkriscv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_resn,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DepthC = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

  state_e        r_state, w_state_nx;
  logic [31:0]   r_pc, w_pc_nx;
  logic [31:0]   r_addr;
  logic [31:0]   r_data [FIFO_DEPTH];
  logic [31:0]   r_dpc  [FIFO_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_count, w_count_nx;
  logic          w_push, w_pop;
  logic          w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  always_comb begin
    w_push     = (r_state == StReq) && i_imem_ack && !i_redirect;
    w_pop      = (r_count != '0) && i_instr_ready;
    w_count_nx = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    w_pc_nx    = r_pc;
    w_state_nx = r_state;
    if (i_redirect) begin
      w_count_nx = '0;
      w_pc_nx    = {i_redirect_pc[31:2], 2'b00};
      // An outstanding request must still be drained before the new PC is fetched.
      w_state_nx = ((r_state != StIdle) && !i_imem_ack) ? StFlush : StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_count_nx < DepthC) w_state_nx = StReq;
        end
        StReq: begin
          if (i_imem_ack) begin
            w_pc_nx    = r_pc + 32'd4;
            w_state_nx = (w_count_nx < DepthC) ? StReq : StIdle;
          end
        end
        StFlush: begin
          if (i_imem_ack) w_state_nx = StIdle;
        end
        default: w_state_nx = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resn) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      // The bus address stays on the abandoned request until it is acknowledged.
      r_addr  <= (w_state_nx == StFlush) ? r_addr : w_pc_nx;
      r_count <= w_count_nx;
      if (i_redirect) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) begin
          r_data[r_wr] <= i_imem_data;
          r_dpc[r_wr]  <= r_pc;
          r_wr         <= r_wr + 1'b1;
        end
        if (w_pop) r_rd <= r_rd + 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_resn) begin
      r_stall_cnt <= '0;
    end else if (r_count == '0) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_imem_req    = (r_state != StIdle);
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = (r_count != '0);
  assign o_instr       = o_instr_valid ? r_data[r_rd] : '0;
  assign o_instr_pc    = o_instr_valid ? r_dpc[r_rd] : '0;

endmodule

// File: tb/tb_darkriscv_fetch_ctrl.sv
// Self-checking bench for darkriscv_fetch_ctrl: cycle vector table, scoreboard of fetched words,
// and hand-written redirect/flush sequences. A second instance checks PC wrap from a high reset PC.
module tb_darkriscv_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resn, ack, redirect, ready;
  logic [31:0] rpc, rdata;
  logic        req, valid;
  logic [31:0] addr, instr, ipc;
  logic        req5, valid5;
  logic [31:0] addr5, instr5, ipc5, rdata5;
  logic        ack5, ready5, redirect5;
  logic [31:0] rpc5;
`ifdef FETCH_STATS_EN
  logic [31:0] stall, stall5;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  assign rdata     = mem_word(addr);
  assign rdata5    = mem_word(addr5);
  assign ack5      = 1'b1;
  assign ready5    = 1'b1;
  assign redirect5 = 1'b0;
  assign rpc5      = 32'h0;

  darkriscv_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_resn(resn), .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack),
    .i_imem_data(rdata), .i_redirect(redirect), .i_redirect_pc(rpc), .o_instr_valid(valid),
    .i_instr_ready(ready), .o_instr(instr), .o_instr_pc(ipc)
`ifdef FETCH_STATS_EN
    , .o_stall_cnt(stall)
`endif
  );

  darkriscv_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut5 (
    .i_clk(clk), .i_resn(resn), .o_imem_req(req5), .o_imem_addr(addr5), .i_imem_ack(ack5),
    .i_imem_data(rdata5), .i_redirect(redirect5), .i_redirect_pc(rpc5), .o_instr_valid(valid5),
    .i_instr_ready(ready5), .o_instr(instr5), .o_instr_pc(ipc5)
`ifdef FETCH_STATS_EN
    , .o_stall_cnt(stall5)
`endif
  );

  int total = 0;
  int bad   = 0;
  int pops;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic        flushing;

  typedef struct {
    logic        rdy;
    logic        ak;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge and score whatever completes on the next posedge.
  task automatic tick(input logic rdy, input logic ak, input logic rd, input logic [31:0] rp);
    exp_t e;
    @(negedge clk);
    ready    = rdy;
    ack      = ak;
    redirect = rd;
    rpc      = rp;
    if (valid && rdy) begin
      pops++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got pc %h with empty scoreboard", ipc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", ipc, e.pc);
        check("pop_instr", instr, e.data);
      end
    end
    if (rd) begin
      sb.delete();
      exp_pc   = {rp[31:2], 2'b00};
      flushing = req && !ak;
    end else if (req && ak) begin
      if (flushing) begin
        flushing = 1'b0;
      end else begin
        check("fetch_addr", addr, exp_pc);
        sb.push_back('{exp_pc, mem_word(exp_pc)});
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resn     = 1'b0;
    ack      = 1'b0;
    redirect = 1'b0;
    ready    = 1'b0;
    rpc      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", ipc, 32'h0);
    check("rst_addr5", addr5, 32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
    check("rst_stall", stall, 32'h0);
`endif
    sb.delete();
    exp_pc   = 32'h0;
    flushing = 1'b0;
    pops     = 0;
    resn     = 1'b1;
  endtask

  initial begin
    // READY low until the FIFO fills, then drain while fetch resumes.
    vt[0] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    vt[8] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    vt[9] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    // Zero-wait memory, always ready: one instruction per clock.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 1) check("t1_first_invalid", {31'b0, valid}, 32'd0);
      else        check("t1_valid", {31'b0, valid}, 32'd1);
    end
    check("t1_pops", 32'(pops), 32'd19);

    // FIFO fill and drain.
    do_reset();
    foreach (vt[i]) begin
      tick(vt[i].rdy, vt[i].ak, 1'b0, 32'h0);
      check("t2_req", {31'b0, req}, {31'b0, vt[i].exp_req});
      check("t2_addr", addr, vt[i].exp_addr);
      check("t2_valid", {31'b0, valid}, {31'b0, vt[i].exp_valid});
      if (vt[i].exp_valid) check("t2_head_pc", ipc, vt[i].exp_pc);
    end

    // Redirect while a request waits: request held, old data dropped.
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t3_req", {31'b0, req}, 32'd1);
    tick(1'b1, 1'b0, 1'b1, 32'h103);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t3_hold_req", {31'b0, req}, 32'd1);
    check("t3_hold_addr", addr, 32'h0);
    check("t3_valid", {31'b0, valid}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_hold_addr2", addr, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t3_idle", {31'b0, req}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_new_req", {31'b0, req}, 32'd1);
    check("t3_new_addr", addr, 32'h100);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t3_new_valid", {31'b0, valid}, 32'd1);
    check("t3_new_pc", ipc, 32'h100);

    // Redirect and ACK in the same cycle with two entries buffered.
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h200);
    check("t4_pre_valid", {31'b0, valid}, 32'd1);
    check("t4_pre_addr", addr, 32'h8);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check("t4_flushed", {31'b0, valid}, 32'd0);
    check("t4_idle", {31'b0, req}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t4_new_addr", addr, 32'h200);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_new_pc", ipc, 32'h200);
    check("t4_new_instr", instr, mem_word(32'h200));

    // PC wrap from a high reset PC (second instance).
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_addr0", addr5, 32'hFFFF_FFF8);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_addr1", addr5, 32'hFFFF_FFFC);
    check("t5_head", ipc5, 32'hFFFF_FFF8);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_addr2", addr5, 32'h0);
    check("t5_head2", ipc5, 32'hFFFF_FFFC);

`ifdef FETCH_STATS_EN
    do_reset();
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    check("t6_stall", stall, 32'd10);
    @(negedge clk);
    resn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_stall_rst", stall, 32'd0);
    resn = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
